// File: rtl/pc_branch_unit.sv
// Fetch PC and redirect sequencer: boot, sequential fetch, one-cycle redirect
// bubble after a taken branch or jump, and a halt that only reset can leave.
module pc_branch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchOffset,
  input  logic [15:0] ExPC,
  input  logic        Jump,
  input  logic [15:0] JumpTarget,
  input  logic        Halt,
  output logic [15:0] PC,
  output logic        FetchValid,
  output logic        Flush,
  output logic        Halted
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t         stateQ, stateD;
  logic [W-1:0]   pcD;
  logic [W-1:0]   branchTarget;
  logic [W-1:0]   jumpAligned;

  // Branch target is relative to the instruction after the branch; wrap is silent.
  assign branchTarget = W'(ExPC + W'(2) + W'(BranchOffset << 1));
  assign jumpAligned  = JumpTarget & ~W'(1);

  // State, PC and decoded status flags
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ     <= BOOT;
      PC         <= RESET_PC;
      FetchValid <= 1'b0;
      Halted     <= 1'b0;
    end else begin
      stateQ     <= stateD;
      PC         <= pcD;
      FetchValid <= (stateD == RUN);
      Halted     <= (stateD == HALTED);
    end
  end

  // Next state, next PC and the combinational flush strobe
  always_comb begin
    stateD = stateQ;
    pcD    = PC;
    Flush  = 1'b0;
    unique case (stateQ)
      BOOT: begin
        stateD = Halt ? HALTED : RUN;
      end
      RUN: begin
        if (Halt) begin
          stateD = HALTED;
        end else if (Stall) begin
          stateD = RUN;
        end else if (Jump) begin
          pcD    = jumpAligned;
          Flush  = 1'b1;
          stateD = BUBBLE;
        end else if (BranchTaken) begin
          pcD    = branchTarget;
          Flush  = 1'b1;
          stateD = BUBBLE;
        end else begin
          pcD    = W'(PC + W'(PC_STEP));
        end
      end
      BUBBLE: begin
        stateD = Halt ? HALTED : RUN;
      end
      HALTED: begin
        stateD = HALTED;
      end
      default: begin
        stateD = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: boot, branches, wrap, stall, jump, halt, async reset.
module tb_pc_branch_unit;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchOffset;
  logic [15:0] ExPC;
  logic        Jump;
  logic [15:0] JumpTarget;
  logic        Halt;
  logic [15:0] PC;
  logic        FetchValid;
  logic        Flush;
  logic        Halted;

  int total = 0;
  int bad   = 0;

  pc_branch_unit dut (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchOffset (BranchOffset),
    .ExPC         (ExPC),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Halt         (Halt),
    .PC           (PC),
    .FetchValid   (FetchValid),
    .Flush        (Flush),
    .Halted       (Halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Registered outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chkRun(input string tag, input logic [15:0] pc, input logic fv);
    chk({tag, ".pc"}, PC, pc);
    chk({tag, ".fv"}, {15'd0, FetchValid}, {15'd0, fv});
  endtask

  initial begin
    Reset_n = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchOffset = 16'h0;
    ExPC = 16'h0; Jump = 1'b0; JumpTarget = 16'h0; Halt = 1'b0;

    // Reset and boot
    tick(); tick();
    chkRun("rst", 16'h0000, 1'b0);
    chk("rst.halted", {15'd0, Halted}, 16'd0);
    chk("rst.flush", {15'd0, Flush}, 16'd0);
    Reset_n = 1'b1;
    #1;
    chkRun("boot", 16'h0000, 1'b0);
    tick(); chkRun("run0", 16'h0000, 1'b1);
    tick(); chkRun("run1", 16'h0002, 1'b1);
    tick(); chkRun("run2", 16'h0004, 1'b1);
    repeat (6) tick();
    chkRun("run10", 16'h0010, 1'b1);

    // Taken branch: 000C + 2 + (5<<1) = 0018
    ExPC = 16'h000C; BranchOffset = 16'h0005; BranchTaken = 1'b1;
    #1; chk("br.flush", {15'd0, Flush}, 16'd1);
    tick(); chkRun("br.bub", 16'h0018, 1'b0);
    chk("br.bubflush", {15'd0, Flush}, 16'd0);
    BranchTaken = 1'b0;
    tick(); chkRun("br.tgt", 16'h0018, 1'b1);
    tick(); chkRun("br.seq", 16'h001A, 1'b1);

    // Negative offset: 0002 + 2 - 6 = FFFE, then sequential wrap
    ExPC = 16'h0002; BranchOffset = 16'hFFFD; BranchTaken = 1'b1;
    #1; chk("neg.flush", {15'd0, Flush}, 16'd1);
    tick(); chkRun("neg.bub", 16'hFFFE, 1'b0);
    BranchTaken = 1'b0;
    tick(); chkRun("neg.tgt", 16'hFFFE, 1'b1);
    tick(); chkRun("wrap", 16'h0000, 1'b1);

    // Stall holds PC and masks the redirect; target 0020 + 2 = 0022
    Stall = 1'b1; BranchTaken = 1'b1; ExPC = 16'h0020; BranchOffset = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1; chk("stall.flush", {15'd0, Flush}, 16'd0);
      tick(); chkRun("stall.pc", 16'h0000, 1'b1);
    end
    Stall = 1'b0;
    #1; chk("unstall.flush", {15'd0, Flush}, 16'd1);
    tick(); chkRun("unstall.bub", 16'h0022, 1'b0);
    BranchTaken = 1'b0;
    tick(); chkRun("unstall.tgt", 16'h0022, 1'b1);

    // Jump beats branch, bit 0 cleared
    Jump = 1'b1; JumpTarget = 16'h0123; BranchTaken = 1'b1;
    ExPC = 16'h0000; BranchOffset = 16'h0100;
    #1; chk("jmp.flush", {15'd0, Flush}, 16'd1);
    tick(); chkRun("jmp.bub", 16'h0122, 1'b0);
    chk("jmp.flush1", {15'd0, Flush}, 16'd0);
    Jump = 1'b0; BranchTaken = 1'b0;
    tick(); chkRun("jmp.tgt", 16'h0122, 1'b1);
    chk("jmp.flush2", {15'd0, Flush}, 16'd0);

    // Reach 0040, then halt
    Jump = 1'b1; JumpTarget = 16'h0040;
    tick(); Jump = 1'b0;
    tick(); chkRun("pre.halt", 16'h0040, 1'b1);
    Halt = 1'b1; BranchTaken = 1'b1; ExPC = 16'h0100;
    #1; chk("halt.flush", {15'd0, Flush}, 16'd0);
    tick(); chkRun("halt", 16'h0040, 1'b0);
    chk("halt.halted", {15'd0, Halted}, 16'd1);
    Halt = 1'b0; Jump = 1'b1; JumpTarget = 16'h0080;
    #1; chk("halt.noflush", {15'd0, Flush}, 16'd0);
    tick(); tick();
    chkRun("halt.frozen", 16'h0040, 1'b0);
    chk("halt.stay", {15'd0, Halted}, 16'd1);

    // Async reset mid-cycle takes effect before the next edge
    Jump = 1'b0; BranchTaken = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    chkRun("arst", 16'h0000, 1'b0);
    chk("arst.halted", {15'd0, Halted}, 16'd0);
    tick();
    Reset_n = 1'b1;
    #1; chkRun("arst.boot", 16'h0000, 1'b0);
    tick(); chkRun("arst.run0", 16'h0000, 1'b1);
    tick(); chkRun("arst.run1", 16'h0002, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and redirect stage that sits directly downstream of the branch comparator.
- Consumes the comparator's 1-bit taken result, bit 0 of its 16-bit output.
- Holds the fetch PC, computes the sequential and branch/jump targets, and flushes the two younger pipeline stages on a redirect.
- Sequences boot, normal fetch, a one-cycle redirect bubble, and halt.

Parameters:
- RESET_PC, 16'h0000, fetch address loaded on reset.
- PC_STEP, 2, byte increment per sequential fetch; instructions are 16-bit.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Stall  input  1  pipeline freeze from hazard logic.
- BranchTaken  input  1  comparator result bit 0: equal and branch-enable.
- BranchOffset  input  16  signed word offset of the branch in the compare stage.
- ExPC  input  16  PC of the instruction currently in the compare stage.
- Jump  input  1  unconditional jump in the compare stage.
- JumpTarget  input  16  absolute jump address.
- Halt  input  1  halt request.
- PC  output  16  current fetch address.
- FetchValid  output  1  PC is a valid fetch this cycle.
- Flush  output  1  discard the IF and ID instructions at this edge.
- Halted  output  1  unit is stopped.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on Reset_n.
- Reset values: PC=RESET_PC, state=BOOT, FetchValid=0, Flush=0, Halted=0.
- Reset mid-operation aborts any redirect or halt immediately.
- States: BOOT, RUN, BUBBLE, HALTED.
- BOOT:
  - FetchValid=0 and PC is held.
  - Next state is RUN unconditionally, unless Halt=1, which goes to HALTED.
- RUN: first matching rule wins, evaluated each cycle.
  1. Halt=1: go to HALTED; PC is held; Flush=0.
  2. Stall=1: PC is held; BranchTaken and Jump are ignored because the compare stage is frozen and will re-present them.
  3. Jump=1:
     - next PC = {JumpTarget[15:1],1'b0}.
     - Flush=1 combinationally this cycle; go to BUBBLE.
  4. BranchTaken=1:
     - next PC = ExPC + 2 + (BranchOffset<<1), truncated to 16 bits so wrap-around is silent.
     - Flush=1 combinationally this cycle; go to BUBBLE.
  5. Otherwise: PC = PC + PC_STEP, wrapping at 16'hFFFE to 16'h0000.
- Simultaneous Jump and BranchTaken: Jump wins.
- FetchValid=1 in RUN only.
- BUBBLE:
  - FetchValid=0, Flush=0, and PC holds the redirect target.
  - Next state is RUN; Halt=1 instead goes to HALTED.
  - A Stall arriving in BUBBLE does not extend the bubble.
  - Redirect inputs are ignored in BUBBLE.
- HALTED:
  - Halted=1, FetchValid=0, PC is frozen.
  - The only exit is reset.
- Flush:
  - Purely combinational, asserted in RUN only.
  - Width is exactly one cycle per redirect.
  - Never asserted while Stall=1 or Halt=1.
- Latency: redirect target appears on PC one cycle after the resolving edge. The first valid fetch of the target is two cycles after that edge, in RUN after BUBBLE.

Test Plan:
- Reset and boot:
  - Stimulus: assert Reset_n=0, then release with no other inputs active.
  - Response: PC=0000 with FetchValid=0 for one cycle, then PC=0000, 0002, 0004 with FetchValid=1.
- Taken branch:
  - Stimulus: in RUN at PC=0010, drive ExPC=000C, BranchOffset=0005, BranchTaken=1.
  - Response: Flush=1 that cycle; next PC=0018 with FetchValid=0; following cycle PC=0018 with FetchValid=1, then 001A.
- Negative offset and wrap:
  - Stimulus: ExPC=0002, BranchOffset=FFFD (-3).
  - Response: target=FFFE.
  - Stimulus: sequential fetch at PC=FFFE.
  - Response: next PC=0000.
- Stall priority:
  - Stimulus: Stall=1 together with BranchTaken=1 for 3 cycles, then Stall=0.
  - Response: PC holds and Flush=0 during the stall; the redirect fires with Flush=1 on the first unstalled cycle.
- Jump beats branch:
  - Stimulus: Jump=1, JumpTarget=0123, BranchTaken=1.
  - Response: next PC=0122 (bit 0 forced to 0) and a single Flush pulse.
- Halt then async reset:
  - Stimulus: Halt=1 at PC=0040.
  - Response: Halted=1, PC stays 0040, and later redirects have no effect.
  - Stimulus: pulse Reset_n low mid-cycle.
  - Response: PC=0000 and state=BOOT immediately, without waiting for a clock edge.
